// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation encodings and
// the width helper used to size the return-stack occupancy count.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BR   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } pc_op_e;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address stack: push/pop at the top, occupancy count, and the top
// entry presented combinationally for a same-cycle RET.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [sp_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = sp_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;

  // Guards here keep the stack consistent even if a caller misbehaves.
  assign do_push = push && (count_q != FULL);
  assign do_pop  = pop && !push && (count_q != '0);

  // Low bits of the count address the next free slot; top is one below.
  assign wr_idx = count_q[PW-1:0];
  assign rd_idx = count_q[PW-1:0] - PW'(1);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_idx] = push_data;
      count_d       = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Entry contents carry no reset; anything above the count is don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign top   = mem_q[rd_idx];
  assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential step, absolute jump, relative branch and
// call/return through a small return-address stack with a sticky error flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STEP         = 1,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic                             En,
  input  logic [2:0]                       Op,
  input  logic [WIDTH-1:0]                 E,
  output logic [WIDTH-1:0]                 Saida,
  output logic [sp_width(STACK_DEPTH)-1:0] Depth,
  output logic                             Err
);

  localparam int CW = sp_width(STACK_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RV_W   = WIDTH'(RESET_VECTOR);
  localparam logic [CW-1:0]    FULL   = CW'(STACK_DEPTH);

  logic [WIDTH-1:0] saida_q, saida_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] next_seq;
  logic [WIDTH-1:0] stk_top;
  logic [CW-1:0]    stk_count;
  logic             stk_push, stk_pop;

  assign next_seq = saida_q + STEP_W;

  always_comb begin
    saida_d  = saida_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (En) begin
      case (pc_op_e'(Op))
        OP_INC: saida_d = next_seq;
        OP_JMP: saida_d = E;
        // Two's-complement add gives signed offset and wrap in both directions.
        OP_BR:  saida_d = saida_q + E;
        OP_CALL: begin
          saida_d = E;
          if (stk_count == FULL) begin
            err_d = 1'b1;
          end else begin
            stk_push = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_count == '0) begin
            saida_d = next_seq;
            err_d   = 1'b1;
          end else begin
            saida_d = stk_top;
            stk_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      saida_q <= RV_W;
      err_q   <= 1'b0;
    end else begin
      saida_q <= saida_d;
      err_q   <= err_d;
    end
  end

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (Reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (next_seq),
    .top       (stk_top),
    .count     (stk_count)
  );

  assign Saida = saida_q;
  assign Depth = stk_count;
  assign Err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues expected state per issued
// cycle, the monitor pops and compares after each edge or reset probe.
module tb_pc_unit;

  logic        clk;
  logic        Reset;
  logic        En;
  logic [2:0]  Op;
  logic [15:0] E;
  logic [15:0] saida1, saida2;
  logic [2:0]  depth1, depth2;
  logic        err1, err2;

  // record layout: {dut_sel, saida[15:0], depth[2:0], err}
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          n_cmp;
  int          n_bad;
  event        sample_ev;

  pc_unit #(.WIDTH(16), .STEP(1), .RESET_VECTOR(0), .STACK_DEPTH(4)) u_dut (
    .clk(clk), .Reset(Reset), .En(En), .Op(Op), .E(E),
    .Saida(saida1), .Depth(depth1), .Err(err1)
  );

  pc_unit #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'hFFFE), .STACK_DEPTH(4)) u_dut2 (
    .clk(clk), .Reset(Reset), .En(En), .Op(Op), .E(E),
    .Saida(saida2), .Depth(depth2), .Err(err2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor
  initial begin
    logic [20:0] rec;
    logic [19:0] got;
    string       nm;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = rec[20] ? {saida2, depth2, err2} : {saida1, depth1, err1};
        n_cmp++;
        if (got !== rec[19:0]) begin
          n_bad++;
          $display("FAIL %s: got saida=%h depth=%0d err=%b, want saida=%h depth=%0d err=%b",
                   nm, got[19:4], got[3:1], got[0], rec[19:4], rec[3:1], rec[0]);
        end
      end
    end
  end

  task automatic expect_st(input logic sel, input logic [15:0] xs, input logic [2:0] xd,
                           input logic xe, input string nm);
    exp_q.push_back({sel, xs, xd, xe});
    name_q.push_back(nm);
  endtask

  // Drive one cycle at the falling edge; its result is checked after the next rise.
  task automatic step(input logic en, input logic [2:0] op, input logic [15:0] e,
                      input logic [15:0] xs, input logic [2:0] xd, input logic xe,
                      input string nm);
    @(negedge clk);
    En = en;
    Op = op;
    E  = e;
    expect_st(1'b0, xs, xd, xe, nm);
  endtask

  initial begin
    Reset = 1'b1;
    En    = 1'b0;
    Op    = 3'b000;
    E     = 16'h0000;
    #1 Reset = 1'b0;
    #1;
    expect_st(1'b0, 16'h0000, 3'd0, 1'b0, "reset_dut1");
    expect_st(1'b1, 16'hFFFE, 3'd0, 1'b0, "reset_dut2");
    -> sample_ev;
    @(negedge clk);
    Reset = 1'b1;

    // sequential fetch, and STEP=2 wrap on the second instance
    step(1'b1, 3'b000, 16'h0000, 16'h0001, 3'd0, 1'b0, "inc_1");
    expect_st(1'b1, 16'h0000, 3'd0, 1'b0, "inc_step2_wrap");
    step(1'b1, 3'b000, 16'h0000, 16'h0002, 3'd0, 1'b0, "inc_2");
    step(1'b1, 3'b000, 16'h0000, 16'h0003, 3'd0, 1'b0, "inc_3");

    // jumps and branches, including wrap both ways
    step(1'b1, 3'b001, 16'h0010, 16'h0010, 3'd0, 1'b0, "jmp_0010");
    step(1'b1, 3'b010, 16'hFFFC, 16'h000C, 3'd0, 1'b0, "br_back4");
    step(1'b1, 3'b001, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, "jmp_ffff");
    step(1'b1, 3'b000, 16'h0000, 16'h0000, 3'd0, 1'b0, "inc_wrap");
    step(1'b1, 3'b001, 16'h0002, 16'h0002, 3'd0, 1'b0, "jmp_0002");
    step(1'b1, 3'b010, 16'hFFFC, 16'hFFFE, 3'd0, 1'b0, "br_wrap_down");
    step(1'b1, 3'b010, 16'h0003, 16'h0001, 3'd0, 1'b0, "br_wrap_up");

    // nested call / return, back to back
    step(1'b1, 3'b001, 16'h0020, 16'h0020, 3'd0, 1'b0, "jmp_0020");
    step(1'b1, 3'b011, 16'h0100, 16'h0100, 3'd1, 1'b0, "call_0100");
    step(1'b1, 3'b011, 16'h0200, 16'h0200, 3'd2, 1'b0, "call_0200");
    step(1'b1, 3'b100, 16'h0000, 16'h0101, 3'd1, 1'b0, "ret_0101");
    step(1'b1, 3'b100, 16'h0000, 16'h0021, 3'd0, 1'b0, "ret_0021");

    // hold encodings with En=1
    for (int k = 5; k < 8; k++)
      step(1'b1, 3'(k), 16'h1234, 16'h0021, 3'd0, 1'b0, "hold_op");

    // stall with a live stack entry, every opcode
    step(1'b1, 3'b011, 16'h0300, 16'h0300, 3'd1, 1'b0, "call_0300");
    for (int k = 0; k < 8; k++)
      step(1'b0, 3'(k), 16'h0ABC, 16'h0300, 3'd1, 1'b0, "stall_op");
    step(1'b1, 3'b100, 16'h0000, 16'h0022, 3'd0, 1'b0, "ret_after_stall");

    // overflow: fifth call jumps but does not push
    step(1'b1, 3'b011, 16'h1000, 16'h1000, 3'd1, 1'b0, "call_1");
    step(1'b1, 3'b011, 16'h2000, 16'h2000, 3'd2, 1'b0, "call_2");
    step(1'b1, 3'b011, 16'h3000, 16'h3000, 3'd3, 1'b0, "call_3");
    step(1'b1, 3'b011, 16'h4000, 16'h4000, 3'd4, 1'b0, "call_4");
    step(1'b1, 3'b011, 16'h5000, 16'h5000, 3'd4, 1'b1, "call_5_ovf");
    step(1'b1, 3'b100, 16'h0000, 16'h3001, 3'd3, 1'b1, "ret_after_ovf");

    // reset pulse between edges; first edge after release acts on INC
    @(negedge clk);
    En = 1'b1;
    Op = 3'b000;
    E  = 16'h0000;
    #1 Reset = 1'b0;
    #1;
    expect_st(1'b0, 16'h0000, 3'd0, 1'b0, "async_reset");
    -> sample_ev;
    #1 Reset = 1'b1;
    #1;
    expect_st(1'b0, 16'h0001, 3'd0, 1'b0, "first_edge_after_reset");

    // underflow, then sticky error
    step(1'b1, 3'b100, 16'h0000, 16'h0002, 3'd0, 1'b1, "ret_underflow");
    step(1'b1, 3'b000, 16'h0000, 16'h0003, 3'd0, 1'b1, "err_sticky");

    // reset held across a CALL edge discards it
    @(negedge clk);
    Op = 3'b011;
    E  = 16'h0700;
    #1 Reset = 1'b0;
    #1;
    expect_st(1'b0, 16'h0000, 3'd0, 1'b0, "reset_in_call");
    -> sample_ev;
    #1;
    expect_st(1'b0, 16'h0000, 3'd0, 1'b0, "call_discarded");
    @(negedge clk);
    Reset = 1'b1;
    expect_st(1'b0, 16'h0700, 3'd1, 1'b0, "call_after_release");

    @(negedge clk);
    En = 1'b0;
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
